// File: rtl/four_input_irq_aggregator.sv
// four_input_irq_aggregator
//   Collects four asynchronous request lines into sticky pending flags and
//   a single maskable interrupt. It also keeps a saturating count of irq
//   assertions.
//
//   Parameters
//     SYNC_STAGES : synchronizer depth per request bit (2..4)
//     CNT_W       : width of irq_cnt
//
//   Ports
//     clk      in   single clock, rising edge
//     rst_n    in   asynchronous active-low reset, clears all state
//     req_in   in   [3:0] asynchronous request lines, bit i = source i
//     mask     in   [3:0] 1 = source i does not contribute to irq (sync to clk)
//     clr      in   [3:0] write-1-to-clear pulse for pending[i] (sync to clk)
//     cnt_clr  in   synchronous clear of irq_cnt
//     pending  out  [3:0] sticky per-source event flags
//     irq      out  registered OR of unmasked pending bits
//     irq_cnt  out  [CNT_W-1:0] saturating count of irq 0->1 transitions
module four_input_irq_aggregator #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_in,
  input  logic [3:0]       mask,
  input  logic [3:0]       clr,
  input  logic             cnt_clr,
  output logic [3:0]       pending,
  output logic             irq,
  output logic [CNT_W-1:0] irq_cnt
);

  localparam int unsigned     CHAIN_W = SYNC_STAGES * 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The synchronizer stages are packed side by side: stage 0 occupies bits
  // [3:0] and the last stage occupies the top nibble. This lets the whole
  // chain shift as one vector.
  logic [CHAIN_W-1:0] sync_chain;
  logic [3:0]         sync;
  logic [3:0]         sync_d;
  logic [3:0]         rise;

  logic [3:0]         pending_next;
  logic               irq_next;
  logic               cnt_inc;

  assign sync = sync_chain[CHAIN_W-1 -: 4];

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
      sync_d     <= '0;
    end else begin
      sync_chain <= {sync_chain[CHAIN_W-5:0], req_in};
      sync_d     <= sync;
    end
  end

  // Event logic. A new rise has priority over a clear in the same cycle, so
  // an event that arrives while software is clearing the flag is kept.
  always_comb begin
    rise         = sync & ~sync_d;
    pending_next = (pending & ~clr) | rise;
    irq_next     = |(pending & ~mask);
    cnt_inc      = irq_next & ~irq & (irq_cnt != CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_next;
      irq     <= irq_next;
    end
  end

  // The count saturates at all-ones. A clear takes priority over an
  // increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_cnt <= '0;
    end else if (cnt_clr) begin
      irq_cnt <= '0;
    end else if (cnt_inc) begin
      irq_cnt <= irq_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_four_input_irq_aggregator.sv
module tb_four_input_irq_aggregator;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic [3:0] clr;
  logic       cnt_clr;

  logic [3:0] pending8, pending2;
  logic       irq8, irq2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int total;
  int bad;

  four_input_irq_aggregator #(.SYNC_STAGES(2), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .clr(clr),
    .cnt_clr(cnt_clr), .pending(pending8), .irq(irq8), .irq_cnt(cnt8)
  );

  four_input_irq_aggregator #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .clr(clr),
    .cnt_clr(cnt_clr), .pending(pending2), .irq(irq2), .irq_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] msk;
    logic [3:0] clr;
    logic       cc;
    logic [3:0] ep;
    logic       eirq;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs [31];

  function automatic vec_t mk(logic [3:0] r, logic [3:0] m, logic [3:0] c, logic cc,
                              logic [3:0] ep, logic ei, logic [7:0] ec);
    vec_t v;
    v.req = r; v.msk = m; v.clr = c; v.cc = cc;
    v.ep = ep; v.eirq = ei; v.ecnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] ep, input logic ei,
                         input logic [7:0] e8, input logic [1:0] e2);
    chk({name, ".pending8"}, {4'b0, pending8}, {4'b0, ep});
    chk({name, ".pending2"}, {4'b0, pending2}, {4'b0, ep});
    chk({name, ".irq8"},     {7'b0, irq8},     {7'b0, ei});
    chk({name, ".irq2"},     {7'b0, irq2},     {7'b0, ei});
    chk({name, ".cnt8"},     cnt8,             e8);
    chk({name, ".cnt2"},     {6'b0, cnt2},     {6'b0, e2});
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic [3:0] m, input logic [3:0] c,
                      input logic cc);
    req_in = r; mask = m; clr = c; cnt_clr = cc;
    @(posedge clk);
    #1;
  endtask

  // Pulse the given bits and raise irq. Optionally clear the pending bits
  // afterwards and let irq fall. Starts and ends with the synchronizers idle.
  task automatic pulse(input string name, input logic [3:0] bits, input logic cc_at_rise,
                       input logic clear_after, input logic [7:0] e8, input logic [1:0] e2,
                       input logic [7:0] prev8, input logic [1:0] prev2);
    step(bits, 4'b0, 4'b0, 1'b0);
    step(bits, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0, 4'b0, 1'b0);
    chk_all({name, ".set"}, bits, 1'b0, prev8, prev2);
    step(4'b0, 4'b0, 4'b0, cc_at_rise);
    chk_all({name, ".rise"}, bits, 1'b1, e8, e2);
    if (clear_after) begin
      step(4'b0, 4'b0, bits, 1'b0);
      step(4'b0, 4'b0, 4'b0, 1'b0);
      chk_all({name, ".fall"}, 4'b0, 1'b0, e8, e2);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //            req      mask     clr      cc    pend     irq   cnt
    vecs[0]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0);
    vecs[1]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0);
    vecs[2]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'd0);
    vecs[3]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'd1);
    vecs[4]  = mk(4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'd1);
    vecs[5]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    vecs[6]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    vecs[7]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    vecs[8]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    vecs[9]  = mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    vecs[10] = mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'd1);
    vecs[12] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'd2);
    vecs[13] = mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'd2);
    vecs[14] = mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'd2);
    vecs[15] = mk(4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'd2);
    vecs[16] = mk(4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'd2);
    vecs[17] = mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    vecs[18] = mk(4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'd2);
    vecs[19] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    vecs[20] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    vecs[21] = mk(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    vecs[22] = mk(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    vecs[23] = mk(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 8'd2);
    vecs[24] = mk(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 8'd2);
    vecs[25] = mk(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 8'd2);
    vecs[26] = mk(4'b0000, 4'b1110, 4'b0000, 1'b0, 4'b1111, 1'b1, 8'd3);
    vecs[27] = mk(4'b0000, 4'b1110, 4'b0000, 1'b0, 4'b1111, 1'b1, 8'd3);
    vecs[28] = mk(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 8'd3);
    vecs[29] = mk(4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'd3);
    vecs[30] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd3);

    // Reset state, checked before any clock edge.
    rst_n = 1'b0; req_in = '0; mask = '0; clr = '0; cnt_clr = 1'b0;
    #1;
    chk_all("reset_noclk", 4'b0, 1'b0, 8'd0, 2'd0);
    #21;
    rst_n = 1'b1;
    #1;
    chk_all("reset_release", 4'b0, 1'b0, 8'd0, 2'd0);

    for (int i = 0; i < 31; i++) begin
      step(vecs[i].req, vecs[i].msk, vecs[i].clr, vecs[i].cc);
      chk_all($sformatf("vec%0d", i), vecs[i].ep, vecs[i].eirq, vecs[i].ecnt,
              vecs[i].ecnt[1:0]);
    end

    // A counter clear coinciding with an irq rise leaves the count at zero.
    pulse("cnt_clr_race", 4'b0010, 1'b1, 1'b1, 8'd0, 2'd0, 8'd3, 2'd3);

    // Five irq rises: the 8-bit count reaches 5 and the 2-bit count stops at 3.
    // The last rise leaves pending=1011 and irq=1 for the reset test.
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e8;
      logic [1:0] e2;
      logic [7:0] p8;
      logic [1:0] p2;
      e8 = 8'(i + 1);
      e2 = (i + 1 >= 3) ? 2'd3 : 2'(i + 1);
      p8 = 8'(i);
      p2 = (i >= 3) ? 2'd3 : 2'(i);
      if (i < 4)
        pulse($sformatf("sat%0d", i), 4'b0100, 1'b0, 1'b1, e8, e2, p8, p2);
      else
        pulse($sformatf("sat%0d", i), 4'b1011, 1'b0, 1'b0, e8, e2, p8, p2);
    end

    // Reset asserted between edges clears everything at once.
    #3;
    rst_n  = 1'b0;
    req_in = 4'b1000;
    #1;
    chk_all("rst_mid_immediate", 4'b0, 1'b0, 8'd0, 2'd0);
    @(posedge clk);
    #1;
    chk_all("rst_mid_held", 4'b0, 1'b0, 8'd0, 2'd0);
    #2;
    rst_n = 1'b1;

    // A request held high through reset release is seen as a new rise.
    step(4'b1000, 4'b0, 4'b0, 1'b0);
    chk_all("post_rst_e1", 4'b0, 1'b0, 8'd0, 2'd0);
    step(4'b1000, 4'b0, 4'b0, 1'b0);
    chk_all("post_rst_e2", 4'b0, 1'b0, 8'd0, 2'd0);
    step(4'b1000, 4'b0, 4'b0, 1'b0);
    chk_all("post_rst_e3", 4'b1000, 1'b0, 8'd0, 2'd0);
    step(4'b1000, 4'b0, 4'b0, 1'b0);
    chk_all("post_rst_e4", 4'b1000, 1'b1, 8'd1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
